adder_pipe: RTL and testbench

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pkg.sv | 16 +
 rtl/adder_chunk.sv | 35 +++
 rtl/full_adder.sv | 15 +
 rtl/adder_pipe.sv | 148 ++++++++++++++
 tb/tb_adder_pipe.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared defaults and elaboration helpers for the pipelined adder.
//   WIDTH_DEF   : default operand width
//   CHUNK_DEF   : default bits resolved per pipeline stage
//   stage_count : number of pipeline stages (ceil(width/chunk))
package adder_pkg;

    localparam int unsigned WIDTH_DEF = 9;
    localparam int unsigned CHUNK_DEF = 3;

    // Ceiling division; a partial final chunk still needs its own stage.
    function automatic int unsigned stage_count(input int unsigned width,
                                                input int unsigned chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// N-bit ripple-carry adder built from full_adder cells; one per pipeline stage.
//   a, b  : chunk operands (b already inverted for subtraction)
//   cin   : carry into bit 0
//   s     : chunk sum
//   cout  : carry out of bit N-1
//   cmsb  : carry into bit N-1 (used for signed overflow when this is the top chunk)
module adder_chunk #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[N];
    assign cmsb = c[N-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder, the leaf cell of every carry chain.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit resolving CHUNK bits per stage with a
// valid/ready handshake and a single global advance enable.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_ready = advance enable)
//   a, b, sub           : operands; sub=1 selects a-b
//   out_valid/out_ready : result handshake
//   sum                 : {carry-out, WIDTH-bit result}
//   ovf                 : signed overflow of the WIDTH-bit result
//   busy                : some stage holds a valid entry
module adder_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned STAGES = stage_count(WIDTH, CHUNK);
    localparam int unsigned LAST_W = WIDTH - (STAGES - 1) * CHUNK;
    // Intermediate registers; the final stage lands directly in sum/ovf/out_valid.
    localparam int unsigned NREG   = (STAGES > 1) ? STAGES - 1 : 1;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] lo;     // bits resolved so far
        logic [WIDTH-1:0] a;      // operand A (upper bits still pending)
        logic [WIDTH-1:0] b;      // operand B, pre-inverted for subtraction
        logic             carry;  // carry into the next chunk
        logic             cmsb;   // carry into the MSB
    } stage_t;

    logic       adv;
    stage_t     s_in  [STAGES];
    stage_t     s_res [STAGES];
    stage_t     st_q  [NREG];
    stage_t     st_d  [NREG];
    logic [WIDTH:0] sum_q, sum_d;
    logic       ovf_q, ovf_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;

    // Whole pipe moves together; it stalls only when a result is stuck at the output.
    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    // Per-stage chunk resolution.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * CHUNK;
        localparam int unsigned CW = (k == STAGES - 1) ? LAST_W : CHUNK;

        logic [CW-1:0] cs;
        logic          cout;
        logic          cmsb;
        stage_t        r;

        if (k == 0) begin : g_head
            assign s_in[k] = '{valid: in_valid & adv,
                               lo:    '0,
                               a:     a,
                               b:     b ^ {WIDTH{sub}},
                               carry: sub,
                               cmsb:  1'b0};
        end else begin : g_body
            assign s_in[k] = st_q[k-1];
        end

        adder_chunk #(.N(CW)) u_chunk (
            .a    (s_in[k].a[LO +: CW]),
            .b    (s_in[k].b[LO +: CW]),
            .cin  (s_in[k].carry),
            .s    (cs),
            .cout (cout),
            .cmsb (cmsb)
        );

        // Only the top chunk's cmsb survives to the output stage.
        always_comb begin
            r               = s_in[k];
            r.lo[LO +: CW]  = cs;
            r.carry         = cout;
            r.cmsb          = cmsb;
        end

        assign s_res[k] = r;
    end

    // Next-state: shift everything on adv, otherwise hold.
    always_comb begin
        st_d        = st_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        busy_d      = 1'b0;

        if (adv) begin
            for (int unsigned k = 0; k + 1 < STAGES; k++) begin
                st_d[k] = s_res[k];
            end
            out_valid_d = s_res[STAGES-1].valid;
            if (s_res[STAGES-1].valid) begin
                sum_d = {s_res[STAGES-1].carry, s_res[STAGES-1].lo};
                ovf_d = s_res[STAGES-1].carry ^ s_res[STAGES-1].cmsb;
            end
        end

        busy_d = out_valid_d;
        for (int unsigned k = 0; k + 1 < STAGES; k++) begin
            busy_d = busy_d | st_d[k].valid;
        end
    end

    // Datapath fields of intermediate stages are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NREG; k++) begin
                st_q[k].valid <= 1'b0;
            end
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            st_q        <= st_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign sum       = sum_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe (WIDTH=9, CHUNK=3, three stages).
module tb_adder_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] a;
    logic [8:0] b;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] sum;
    logic       ovf;
    logic       busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [8:0] a;
        logic [8:0] b;
        logic       sub;
        logic [9:0] sum;
        logic       ovf;
    } vec_t;

    vec_t vecs [13];
    logic [10:0] exp_q [$];

    adder_pipe #(.WIDTH(9), .CHUNK(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference for streamed traffic: plain integer add plus sign-rule overflow.
    function automatic logic [10:0] model(input logic [8:0] x, input logic [8:0] y, input logic s);
        logic [8:0] yy;
        logic [9:0] t;
        logic       o;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + 10'(s);
        o  = (x[8] == yy[8]) && (t[8] != x[8]);
        return {o, t};
    endfunction

    // Single transaction with out_ready held high; checks latency, sum, ovf.
    task automatic run_vec(input int idx);
        int lat;
        @(negedge clk);
        a        = vecs[idx].a;
        b        = vecs[idx].b;
        sub      = vecs[idx].sub;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk($sformatf("vec%0d_in_ready", idx), in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("vec%0d_latency", idx), lat, 3);
        chk($sformatf("vec%0d_sum", idx), sum, vecs[idx].sum);
        chk($sformatf("vec%0d_ovf", idx), ovf, vecs[idx].ovf);
        @(negedge clk);
        chk($sformatf("vec%0d_no_dup", idx), out_valid, 0);
    endtask

    initial begin
        int sent;
        int got;
        int stalls;
        int stale;
        logic [9:0]  held;
        logic        hold_prev;
        logic [10:0] e;

        vecs[0]  = '{9'd511, 9'd511, 1'b0, 10'h3FE, 1'b0};
        vecs[1]  = '{9'd5,   9'd7,   1'b1, 10'h1FE, 1'b0};
        vecs[2]  = '{9'd7,   9'd5,   1'b1, 10'h202, 1'b0};
        vecs[3]  = '{9'd255, 9'd1,   1'b0, 10'h100, 1'b1};
        vecs[4]  = '{9'd256, 9'd1,   1'b1, 10'h2FF, 1'b1};
        vecs[5]  = '{9'd0,   9'd0,   1'b0, 10'h000, 1'b0};
        vecs[6]  = '{9'd100, 9'd27,  1'b0, 10'h07F, 1'b0};
        vecs[7]  = '{9'd0,   9'd1,   1'b1, 10'h1FF, 1'b0};
        vecs[8]  = '{9'd255, 9'd255, 1'b0, 10'h1FE, 1'b1};
        vecs[9]  = '{9'd256, 9'd256, 1'b0, 10'h200, 1'b1};
        vecs[10] = '{9'd1,   9'd256, 1'b1, 10'h101, 1'b1};
        vecs[11] = '{9'd0,   9'd0,   1'b1, 10'h200, 1'b0};
        vecs[12] = '{9'd63,  9'd1,   1'b0, 10'h040, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_sum", sum, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_vec(i);
        end

        // Back-to-back stream with a four-cycle output stall.
        sent      = 0;
        got       = 0;
        stalls    = 0;
        hold_prev = 1'b0;
        held      = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc < 9);
            if (sent < 8) begin
                in_valid = 1'b1;
                a        = 9'(sent * 37 + 11);
                b        = 9'(sent * 53 + 200);
                sub      = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                chk("stall_in_ready", in_ready, 0);
                if (hold_prev) chk("stall_sum_hold", sum, held);
                held      = sum;
                hold_prev = 1'b1;
            end else begin
                hold_prev = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, 1'b0));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_extra_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("stream%0d_sum", got), sum, e[9:0]);
                    chk($sformatf("stream%0d_ovf", got), ovf, e[10]);
                end
                got++;
            end
        end
        chk("stream_count", got, 8);
        chk("stream_stall_cycles", stalls, 4);

        // Reset with three entries in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            a         = 9'(i + 1);
            b         = 9'(i + 2);
            sub       = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_sum", sum, 0);
        rst_n = 1'b1;
        #1;
        chk("postreset_in_ready", in_ready, 1);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid || busy) stale++;
        end
        chk("postreset_stale", stale, 0);
        run_vec(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
